if_fetch_ctrl: RTL and testbench

- Fetch-side consumer of the PC register: reads pc_reg, issues instruction-memory requests, and drives pc_next and stall back into the PC register.
- Holds issued requests and returned instructions in an in-order ring buffer, presenting them to decode with a valid/ready handshake.
- Handles branch redirects: flushes the buffer and drops in-flight responses.

---
 rtl/if_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: fetch-side controller between the PC register, instruction
// memory and decode. Requests are tracked in an in-order ring buffer; returned
// instructions are presented to decode with a valid/ready handshake. A
// redirect flushes the buffer and discards responses still in flight.
//
// Optional build macro IF_MISALIGN_TRAP_EN: misaligned PCs are not sent to
// memory; a faulting entry is queued instead (id_fault) and the PC is held
// until the next redirect.
module if_fetch_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_reg,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  stall,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [ADDR_WIDTH-1:0] id_pc,
`ifdef IF_MISALIGN_TRAP_EN
    output logic                  id_fault,
`endif
    output logic [INST_WIDTH-1:0] id_inst
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W:0] DEPTH_X = (PTR_W + 1)'(DEPTH);

    // Ring buffer storage
    logic [ADDR_WIDTH-1:0] pc_q     [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_d     [DEPTH];
    logic [INST_WIDTH-1:0] inst_q   [DEPTH];
    logic [INST_WIDTH-1:0] inst_d   [DEPTH];
    logic [DEPTH-1:0]      filled_q;
    logic [DEPTH-1:0]      filled_d;

    // Pointers carry a wrap bit above the index bits
    logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0] fill_ptr_q,  fill_ptr_d;
    logic [PTR_W-1:0] head_ptr_q,  head_ptr_d;
    logic [PTR_W-1:0] drop_cnt_q,  drop_cnt_d;

    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] fill_idx;
    logic [IDX_W-1:0] head_idx;

    logic [PTR_W-1:0] occupancy;
    logic [PTR_W-1:0] outstanding;
    logic [PTR_W:0]   occ_plus_drop;
    logic             space_ok;
    logic             trap_block;
    logic             fault_alloc;
    logic             req_fire;
    logic             resp_drop;
    logic             resp_acc;
    logic             resp_err;
    logic             deq;

`ifdef IF_MISALIGN_TRAP_EN
    logic [DEPTH-1:0] fault_q;
    logic [DEPTH-1:0] fault_d;
    logic             trap_pend_q;
    logic             trap_pend_d;
    logic             misalign;
`endif

    assign alloc_idx = alloc_ptr_q[IDX_W-1:0];
    assign fill_idx  = fill_ptr_q[IDX_W-1:0];
    assign head_idx  = head_ptr_q[IDX_W-1:0];

    // Issue gating: the buffer must have room, and slots still owed to
    // pre-redirect responses count against that room.
    always_comb begin
        occupancy     = alloc_ptr_q - head_ptr_q;
        outstanding   = alloc_ptr_q - fill_ptr_q;
        occ_plus_drop = {1'b0, occupancy} + {1'b0, drop_cnt_q};
        space_ok      = ({1'b0, occupancy} < DEPTH_X) && (occ_plus_drop < DEPTH_X);
`ifdef IF_MISALIGN_TRAP_EN
        misalign      = (pc_reg[1:0] != 2'b00);
        trap_block    = misalign || trap_pend_q;
        // The faulting entry is created already filled, so it may only be
        // queued once every earlier request has been answered; fill_ptr then
        // steps over it together with alloc_ptr.
        fault_alloc   = !reset && !redirect_valid && space_ok && misalign &&
                        !trap_pend_q && (fill_ptr_q == alloc_ptr_q);
`else
        trap_block    = 1'b0;
        fault_alloc   = 1'b0;
`endif
        imem_req_valid = !reset && !redirect_valid && space_ok && !trap_block;
        imem_req_addr  = pc_reg;
        req_fire       = imem_req_valid && imem_req_ready;
    end

    // Response classification and decode-side handshake
    always_comb begin
        resp_drop = imem_resp_valid && (drop_cnt_q != '0);
        resp_acc  = imem_resp_valid && (drop_cnt_q == '0) && (fill_ptr_q != alloc_ptr_q);
        resp_err  = imem_resp_valid && (drop_cnt_q == '0) && (fill_ptr_q == alloc_ptr_q);
        id_valid  = !reset && filled_q[head_idx] && (head_ptr_q != alloc_ptr_q);
        id_pc     = pc_q[head_idx];
        id_inst   = inst_q[head_idx];
`ifdef IF_MISALIGN_TRAP_EN
        id_fault  = fault_q[head_idx];
`endif
        deq       = id_valid && id_ready;
    end

    // PC register control: advance on a handshake, jump on redirect, else hold
    always_comb begin
        pc_next = pc_reg;
        stall   = 1'b1;
        if (reset) begin
            pc_next = pc_reg;
            stall   = 1'b1;
        end else if (redirect_valid) begin
            pc_next = redirect_pc;
            stall   = 1'b0;
        end else if (req_fire) begin
            pc_next = pc_reg + ADDR_WIDTH'(4);
            stall   = 1'b0;
        end
    end

    // Next-state for buffer, pointers and drop counter; redirect overrides last
    always_comb begin
        pc_d        = pc_q;
        inst_d      = inst_q;
        filled_d    = filled_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        drop_cnt_d  = drop_cnt_q;
`ifdef IF_MISALIGN_TRAP_EN
        fault_d     = fault_q;
        trap_pend_d = trap_pend_q;
`endif

        if (req_fire) begin
            pc_d[alloc_idx]     = pc_reg;
            filled_d[alloc_idx] = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            fault_d[alloc_idx]  = 1'b0;
`endif
            alloc_ptr_d         = alloc_ptr_q + PTR_W'(1);
        end

`ifdef IF_MISALIGN_TRAP_EN
        if (fault_alloc) begin
            pc_d[alloc_idx]     = pc_reg;
            inst_d[alloc_idx]   = '0;
            filled_d[alloc_idx] = 1'b1;
            fault_d[alloc_idx]  = 1'b1;
            alloc_ptr_d         = alloc_ptr_q + PTR_W'(1);
            fill_ptr_d          = fill_ptr_q + PTR_W'(1);
            trap_pend_d         = 1'b1;
        end
`endif

        if (resp_drop) begin
            drop_cnt_d = drop_cnt_q - PTR_W'(1);
        end

        if (resp_acc) begin
            inst_d[fill_idx]   = imem_resp_data;
            filled_d[fill_idx] = 1'b1;
            fill_ptr_d         = fill_ptr_q + PTR_W'(1);
        end

        if (deq) begin
            filled_d[head_idx] = 1'b0;
            head_ptr_d         = head_ptr_q + PTR_W'(1);
        end

        if (redirect_valid) begin
            // Everything still owed by memory must be discarded later. A
            // response arriving this cycle retires one of those, whether it
            // was going into the buffer or already being dropped.
            drop_cnt_d  = drop_cnt_q + outstanding - PTR_W'(resp_drop || resp_acc);
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            filled_d    = '0;
`ifdef IF_MISALIGN_TRAP_EN
            fault_d     = '0;
            trap_pend_d = 1'b0;
`endif
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            drop_cnt_q  <= '0;
            filled_q    <= '0;
`ifdef IF_MISALIGN_TRAP_EN
            fault_q     <= '0;
            trap_pend_q <= 1'b0;
`endif
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            drop_cnt_q  <= drop_cnt_d;
            filled_q    <= filled_d;
`ifdef IF_MISALIGN_TRAP_EN
            fault_q     <= fault_d;
            trap_pend_q <= trap_pend_d;
`endif
        end
    end

    // Payload storage; contents are only meaningful while the filled bit is set
    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
    end

`ifndef SYNTHESIS
    // Memory must never answer when nothing is outstanding
    resp_without_request: assert property (@(posedge clk) disable iff (reset) !resp_err);
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed testbench for if_fetch_ctrl (default build, DEPTH=4).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_if_fetch_ctrl;

    localparam int AW = 64;
    localparam int IW = 32;

    logic          clk;
    logic          reset;
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] pc_next;
    logic          stall;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_resp_valid;
    logic [IW-1:0] imem_resp_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_pc;
    logic [IW-1:0] id_inst;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_ctrl #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_reg          (pc_reg),
        .pc_next         (pc_next),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_inst         (id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then leave time to drive inputs
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        id_ready        = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        pc_reg = 64'h0;
        idle_inputs();

        // ---------------- reset ----------------
        step(); step();
        pc_reg = 64'h1234;
        settle();
        check("rst_stall",     {63'b0, stall},          64'd1);
        check("rst_pc_next",   pc_next,                 64'h1234);
        check("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
        check("rst_id_valid",  {63'b0, id_valid},       64'd0);
        step();
        reset = 1'b0;

        // ---------------- streaming fetch ----------------
        pc_reg = 64'h0; imem_req_ready = 1'b1;
        settle();
        check("s0_req_valid", {63'b0, imem_req_valid}, 64'd1);
        check("s0_req_addr",  imem_req_addr,           64'h0);
        check("s0_pc_next",   pc_next,                 64'h4);
        check("s0_stall",     {63'b0, stall},          64'd0);
        step();
        pc_reg = 64'h4; imem_resp_valid = 1'b1; imem_resp_data = 32'h1000_0000;
        settle();
        check("s1_req_addr", imem_req_addr,     64'h4);
        check("s1_pc_next",  pc_next,           64'h8);
        check("s1_id_valid", {63'b0, id_valid}, 64'd0);
        step();
        pc_reg = 64'h8; imem_resp_data = 32'h1000_0004; id_ready = 1'b1;
        settle();
        check("s2_id_valid", {63'b0, id_valid}, 64'd1);
        check("s2_id_pc",    id_pc,             64'h0);
        check("s2_id_inst",  {32'b0, id_inst},  64'h1000_0000);
        check("s2_req_addr", imem_req_addr,     64'h8);
        check("s2_pc_next",  pc_next,           64'hC);
        step();
        pc_reg = 64'hC; imem_req_ready = 1'b0; imem_resp_data = 32'h1000_0008;
        settle();
        check("s3_id_pc",   id_pc,            64'h4);
        check("s3_id_inst", {32'b0, id_inst}, 64'h1000_0004);
        check("s3_stall",   {63'b0, stall},   64'd1);
        check("s3_pc_next", pc_next,          64'hC);
        step();
        imem_resp_valid = 1'b0;
        settle();
        check("s4_id_pc",   id_pc,            64'h8);
        check("s4_id_inst", {32'b0, id_inst}, 64'h1000_0008);
        step();
        id_ready = 1'b0;
        settle();
        check("s5_empty", {63'b0, id_valid}, 64'd0);

        // ---------------- memory not ready ----------------
        pc_reg = 64'h20;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("nr_stall",     {63'b0, stall},          64'd1);
            check("nr_pc_next",   pc_next,                 64'h20);
            check("nr_req_valid", {63'b0, imem_req_valid}, 64'd1);
            step();
        end
        imem_req_ready = 1'b1;
        settle();
        check("nr_go_stall",   {63'b0, stall}, 64'd0);
        check("nr_go_pc_next", pc_next,        64'h24);
        step();
        pc_reg = 64'h24; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1000_0020;
        step();
        imem_resp_valid = 1'b0; id_ready = 1'b1;
        settle();
        check("nr_id_pc",   id_pc,            64'h20);
        check("nr_id_inst", {32'b0, id_inst}, 64'h1000_0020);
        step();
        id_ready = 1'b0;
        settle();
        check("nr_single_entry", {63'b0, id_valid}, 64'd0);

        // ---------------- fill to DEPTH ----------------
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_reg = 64'h40 + 64'(4 * i);
            settle();
            check("full_issue", {63'b0, imem_req_valid}, 64'd1);
            step();
        end
        pc_reg = 64'h50;
        settle();
        check("full_req_valid", {63'b0, imem_req_valid}, 64'd0);
        check("full_stall",     {63'b0, stall},          64'd1);
        check("full_pc_next",   pc_next,                 64'h50);
        for (int i = 0; i < 4; i++) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'h1000_0040 + 32'(4 * i);
            settle();
            check("full_hold", {63'b0, imem_req_valid}, 64'd0);
            step();
        end
        imem_resp_valid = 1'b0;
        id_ready = 1'b1;
        settle();
        check("full_head_pc", id_pc,                   64'h40);
        check("full_no_room", {63'b0, imem_req_valid}, 64'd0);
        step();
        id_ready = 1'b0;
        settle();
        check("release_one",  {63'b0, imem_req_valid}, 64'd1);
        step();
        settle();
        check("release_only_one", {63'b0, imem_req_valid}, 64'd0);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1000_0050;
        step();
        imem_resp_valid = 1'b0; id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("drain_pc", id_pc, 64'h44 + 64'(4 * i));
            check("drain_inst", {32'b0, id_inst}, 64'h1000_0044 + 64'(4 * i));
            step();
        end
        id_ready = 1'b0;
        settle();
        check("drain_empty", {63'b0, id_valid}, 64'd0);

        // ---------------- redirect with two outstanding ----------------
        imem_req_ready = 1'b1;
        pc_reg = 64'h10; step();
        pc_reg = 64'h14; step();
        pc_reg = 64'h18; redirect_valid = 1'b1; redirect_pc = 64'h100;
        settle();
        check("rd_req_valid", {63'b0, imem_req_valid}, 64'd0);
        check("rd_pc_next",   pc_next,                 64'h100);
        check("rd_stall",     {63'b0, stall},          64'd0);
        step();
        redirect_valid = 1'b0;
        pc_reg = 64'h100; imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0010;
        settle();
        check("rd_issue_new", {63'b0, imem_req_valid}, 64'd1);
        step();
        pc_reg = 64'h104; imem_req_ready = 1'b0; imem_resp_data = 32'hBAD0_0014;
        settle();
        check("rd_drop_no_valid", {63'b0, id_valid}, 64'd0);
        step();
        imem_resp_data = 32'h1000_0100;
        settle();
        check("rd_drop2_no_valid", {63'b0, id_valid}, 64'd0);
        step();
        imem_resp_valid = 1'b0; id_ready = 1'b1;
        settle();
        check("rd_first_valid", {63'b0, id_valid}, 64'd1);
        check("rd_first_pc",    id_pc,             64'h100);
        check("rd_first_inst",  {32'b0, id_inst},  64'h1000_0100);
        step();
        id_ready = 1'b0;

        // ---------------- redirect with response, dequeue and issue ----------------
        imem_req_ready = 1'b1;
        pc_reg = 64'h200; step();
        pc_reg = 64'h204; step();
        pc_reg = 64'h208; step();
        pc_reg = 64'h20C; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1000_0200;
        step();
        imem_req_ready = 1'b1; imem_resp_data = 32'hBAD0_0204;
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h300;
        settle();
        check("rx_req_valid", {63'b0, imem_req_valid}, 64'd0);
        check("rx_id_valid",  {63'b0, id_valid},       64'd1);
        check("rx_id_pc",     id_pc,                   64'h200);
        check("rx_pc_next",   pc_next,                 64'h300);
        step();
        redirect_valid = 1'b0; id_ready = 1'b0;
        pc_reg = 64'h300; imem_resp_data = 32'hBAD0_0208;
        settle();
        check("rx_flushed",   {63'b0, id_valid},       64'd0);
        check("rx_can_issue", {63'b0, imem_req_valid}, 64'd1);
        step();
        pc_reg = 64'h304; imem_req_ready = 1'b0; imem_resp_data = 32'h1000_0300;
        settle();
        check("rx_dropped", {63'b0, id_valid}, 64'd0);
        step();
        imem_resp_valid = 1'b0;
        settle();
        check("rx_first_valid", {63'b0, id_valid}, 64'd1);
        check("rx_first_pc",    id_pc,             64'h300);
        check("rx_first_inst",  {32'b0, id_inst},  64'h1000_0300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
